// File: rtl/seq_detector_moore_param_if.sv
// Serial-stream detector bus: data/valid, configuration and status signals.
interface seq_detector_moore_param_if #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned CNT_W = 16
);
   localparam int unsigned LEN_W = $clog2(PAT_W + 1);

   logic             din;
   logic             din_valid;
   logic             cfg_load;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] pat_len;
   logic             overlap_en;
   logic             cnt_clr;
   logic             dout;
   logic [CNT_W-1:0] match_count;
   logic             count_sat;

   modport master (
      output din, din_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
      input  dout, match_count, count_sat
   );

   modport slave (
      input  din, din_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
      output dout, match_count, count_sat
   );
endinterface

// File: rtl/seq_detector_moore_param.sv
// Programmable Moore serial-pattern detector with overlap control and a
// saturating match counter; reset config reproduces the legacy 1010 detector.
module seq_detector_moore_param #(
   parameter int unsigned      PAT_W       = 8,
   parameter int unsigned      CNT_W       = 16,
   parameter int unsigned      LEN_W       = $clog2(PAT_W + 1),
   parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(4'b1010),
   parameter int unsigned      RST_LEN     = 4,
   parameter bit               RST_OVERLAP = 1'b1
) (
   input logic                       clk,
   input logic                       reset,
   seq_detector_moore_param_if.slave bus
);
   localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovl_q, ovl_d;
   logic [PAT_W-1:0] hist_q, hist_d, hist_n, mask;
   logic [LEN_W-1:0] fill_q, fill_d, fill_n, len_eff;
   logic             dout_q, dout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             accept, match;

   // Candidate history after accepting din; only the low len_eff bits are compared.
   always_comb begin
      len_eff = (len_q > PAT_W_L) ? PAT_W_L : len_q;
      hist_n  = {hist_q[PAT_W-2:0], bus.din};
      fill_n  = (fill_q >= PAT_W_L) ? PAT_W_L : fill_q + LEN_W'(1);
      mask    = '0;
      for (int unsigned k = 0; k < PAT_W; k++) begin
         mask[k] = (k < 32'(len_eff));
      end
      match  = (len_eff != '0) && (fill_n >= len_eff) &&
               (((hist_n ^ pat_q) & mask) == '0);
      accept = bus.din_valid && !bus.cfg_load;
   end

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      dout_d = dout_q;
      cnt_d  = cnt_q;
      sat_d  = sat_q;

      if (bus.cfg_load) begin
         pat_d  = bus.pattern;
         len_d  = bus.pat_len;
         ovl_d  = bus.overlap_en;
         hist_d = '0;
         fill_d = '0;
         dout_d = 1'b0;
      end else if (bus.din_valid) begin
         hist_d = hist_n;
         fill_d = (match && !ovl_q) ? '0 : fill_n;
         dout_d = match;
      end

      if (bus.cnt_clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (accept && match) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (cnt_d == '1) begin
            sat_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q  <= RST_PATTERN;
         len_q  <= LEN_W'(RST_LEN);
         ovl_q  <= RST_OVERLAP;
         hist_q <= '0;
         fill_q <= '0;
         dout_q <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         dout_q <= dout_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
      end
   end

   assign bus.dout        = dout_q;
   assign bus.match_count = cnt_q;
   assign bus.count_sat   = sat_q;
endmodule

// File: doc/seq_detector_moore_param.md
Name: seq_detector_moore_param

Overview:
- Parametrised Moore serial-pattern detector; successor to the team's fixed 4-bit "1010" overlapping detector.
- Pattern and pattern length are runtime-programmable up to PAT_W bits.
- Overlapping or non-overlapping detection is selectable per configuration.
- Adds a valid-qualified serial input, a saturating match counter, and reset defaults that reproduce the legacy 1010 overlapping behaviour.
- Sits on the serial-stream monitor path, feeding the status/interrupt logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, match counter width.
- LEN_W, $clog2(PAT_W+1), derived width of pat_len; do not override.
- RST_PATTERN, 'b1010, pattern loaded at reset, zero-extended to PAT_W.
- RST_LEN, 4, pattern length loaded at reset.
- RST_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is accepted on a rising clk edge when high.
- cfg_load  in  1  single-cycle strobe; captures pattern, pat_len and overlap_en.
- pattern  in  PAT_W  pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  in  LEN_W  active pattern length.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_count and count_sat.
- dout  out  1  Moore match output.
- match_count  out  CNT_W  number of matches, saturating.
- count_sat  out  1  sticky flag: match_count has reached all-ones.

Behaviour:
- Reset (async, active-high). On assertion:
  - hist = 0, fill = 0, dout = 0, match_count = 0, count_sat = 0.
  - Shadow config loads RST_PATTERN / RST_LEN / RST_OVERLAP.
- Internal state:
  - hist[PAT_W-1:0] shift register; hist[0] is the newest bit.
  - fill: count of bits accepted since the last restart, saturating at PAT_W.
- Accepted bit (din_valid=1, cfg_load=0):
  - hist_n = {hist[PAT_W-2:0], din}.
  - fill_n = min(fill+1, PAT_W).
- Match condition: len_eff != 0, fill_n >= len_eff, and hist_n[k] == pattern_sh[k] for every k < len_eff.
- Effective length: len_eff = min(pat_len_sh, PAT_W). A stored pat_len of 0 disables detection; no match ever occurs.
- On a match:
  - dout <= 1.
  - If overlap_sh = 1, fill keeps fill_n; the suffix of the match can start the next match.
  - If overlap_sh = 0, fill <= 0; the next match needs len_eff fresh bits.
- Accepted bit without a match: dout <= 0.
- Moore timing:
  - dout is registered and rises in the cycle after the edge that accepts the completing bit. This is one-cycle latency, identical to the legacy FSM.
  - With din_valid=0, hist, fill and dout all hold (the state holds).
- Counter:
  - match_count increments by 1 on each match edge.
  - At all-ones it holds and count_sat <= 1. count_sat stays set until cnt_clr or reset.
  - cnt_clr=1: match_count <= 0 and count_sat <= 0. cnt_clr has priority over a same-edge match; that match is not counted, but dout still asserts.
- cfg_load=1:
  - Shadow config <= inputs; hist <= 0, fill <= 0, dout <= 0.
  - A same-edge din_valid bit is discarded (cfg_load wins).
  - match_count is unaffected.
- Pattern bits at index >= len_eff are ignored.
- Reset asserted mid-stream aborts any partial match immediately; detection resumes from an empty history with the reset config.

Test Plan:
- Reset defaults, stream 1,0,1,0,1,0 (valid every cycle): dout high in the cycles after bit 4 and after bit 6; match_count=2.
- cfg_load with pattern=1010, len=4, overlap_en=0, same stream 1,0,1,0,1,0: only one match, after bit 4; the 1,0 suffix is not reused; match_count=1.
- Stall: with default config, din_valid low for 3 cycles between bits 3 and 4 of 1010: dout stays 0 during the stall, goes 1 after bit 4, and holds 1 through any subsequent din_valid=0 cycles.
- Full-width pattern 8'b11011011, len=8, overlap on, stream 11011011011: matches after bit 8 and bit 11; match_count=2. Also pat_len=0 with the same stream gives no match.
- CNT_W=2 build: 5 matches give match_count=3 and count_sat=1. Then cnt_clr on the same edge as a 6th match gives match_count=0, count_sat=0, dout=1.
- cfg_load on the same edge as the 4th valid bit of 1010: bit discarded, no match, dout=0. Separately, reset pulsed after 101 then 0 applied: no match.
